// File: rtl/common.sv
// Shared cache-bus types and arbitration helpers.
package common;

   typedef enum logic {
      ARB_FIXED,
      ARB_RR
   } arb_mode_t;

   typedef struct packed {
      logic        valid;
      logic        we;
      logic [7:0]  len;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   // Priority pointer after a completed grant: the requester after the winner.
   function automatic int unsigned rr_next(input int unsigned granted, input int unsigned n);
      return (granted + 1 == n) ? 0 : granted + 1;
   endfunction

endpackage

// File: rtl/cbus_rr_arbiter_picker.sv
// Round-robin picker: first valid requester at or after ptr, wrapping.
module rr_picker #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N-1:0]     valid_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [N-1:0] rot;
   int unsigned  src;
   int unsigned  enc;
   int unsigned  sum;

   // Rotate the request vector so the priority holder sits at bit 0
   always_comb begin
      rot = '0;
      src = 0;
      for (int unsigned i = 0; i < N; i++) begin
         src = i + 32'(ptr_i);
         if (src >= N) src = src - N;
         rot[i] = valid_i[src];
      end
   end

   // Lowest set bit of the rotated vector wins
   always_comb begin
      found_o = 1'b0;
      enc     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found_o && rot[i]) begin
            found_o = 1'b1;
            enc     = i;
         end
      end
   end

   // Undo the rotation to get the absolute requester index
   always_comb begin
      sum = enc + 32'(ptr_i);
      if (sum >= N) sum = sum - N;
      idx_o = IDX_W'(sum);
   end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 cache-bus arbiter with zero added grant latency and burst locking.
module cbus_rr_arbiter
   import common::*;
#(
   parameter int unsigned NUM_INPUTS = 2,
   parameter arb_mode_t   MODE       = ARB_RR,
   localparam int unsigned IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
   output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
   output cbus_req_t                    oreq,
   input  cbus_resp_t                   oresp,
   output logic                         busy,
   output logic [IDX_W-1:0]             owner
);

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_e;

   state_e                  state_q;
   logic [IDX_W-1:0]        owner_q;
   logic [IDX_W-1:0]        ptr_q;
   logic [IDX_W-1:0]        ptr_d;
   logic                    busy_q;
   logic [NUM_INPUTS-1:0]   req_valid;
   logic                    found;
   logic [IDX_W-1:0]        pick_idx;
   logic                    grant;
   logic [IDX_W-1:0]        grant_idx;

   // Collect per-requester valid bits for the picker
   always_comb begin
      req_valid = '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         req_valid[i] = ireqs[i].valid;
      end
   end

   rr_picker #(
      .N     (NUM_INPUTS),
      .IDX_W (IDX_W)
   ) u_picker (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .found_o (found),
      .idx_o   (pick_idx)
   );

   // Current grant: locked owner while BUSY, fresh pick while IDLE; nothing during reset
   always_comb begin
      grant     = 1'b0;
      grant_idx = owner_q;
      if (reset) begin
         if (state_q == S_BUSY) begin
            grant = 1'b1;
         end else if (found) begin
            grant     = 1'b1;
            grant_idx = pick_idx;
         end
      end
      ptr_d = IDX_W'(rr_next(32'(grant_idx), NUM_INPUTS));
   end

   // Burst-lock FSM with priority pointer and registered busy flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (found) begin
                  if (oresp.last) begin
                     if (MODE == ARB_RR) ptr_q <= ptr_d;
                  end else begin
                     state_q <= S_BUSY;
                     owner_q <= pick_idx;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_BUSY: begin
               if (oresp.last) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  if (MODE == ARB_RR) ptr_q <= ptr_d;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Route the granted request out and the memory response back to its owner only
   always_comb begin
      oreq   = '0;
      iresps = '0;
      if (grant) begin
         oreq              = ireqs[grant_idx];
         iresps[grant_idx] = oresp;
      end
   end

   assign busy  = busy_q;
   assign owner = grant_idx;

endmodule
